pp_adder_tree_acc: RTL and testbench

Parametrised, pipelined signed adder tree with a saturating group accumulator, for the SD4 MAC datapath. Reduces NUM_PP sign-extended partial products to one exact sum, with one register per tree level. It then accumulates acc_len consecutive valid sums into a saturated ACC_W result. It sits after the partial-product alignment stage and emits one valid-tagged result per accumulation group.

---
 rtl/pp_adder_tree_acc_pkg.sv | 58 +++++
 rtl/pp_adder_tree_acc_if.sv | 30 +++
 rtl/pp_adder_tree_acc_level.sv | 48 ++++
 rtl/pp_adder_tree_acc.sv | 123 ++++++++++++
 tb/tb_pp_adder_tree_acc.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pp_adder_tree_acc_pkg.sv
// Shared constants and helpers for the SD4 MAC adder tree / accumulator datapath.
// Holds the default widths, the tree-shape helpers and the saturating add.
package sd4_mac_pkg;

    localparam int DEF_NUM_PP = 9;
    localparam int DEF_PP_W   = 16;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_LEN_W  = 8;

    typedef struct packed {
        logic signed [63:0] sum;
        logic               ovf;
    } sat_res_t;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            res = ((32'sd1 <<< i) < value) ? i + 1 : res;
        end
        return res;
    endfunction

    // Operand count entering tree level k when the tree starts with n operands.
    function automatic int lvl_count(input int n, input int k);
        int r;
        r = n;
        for (int i = 0; i < k; i++) begin
            r = (r + 1) / 2;
        end
        return r;
    endfunction

    // Operands are already within the width-bit signed range, so the 64-bit sum cannot wrap.
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int                 width);
        sat_res_t           res;
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi) begin
            res.sum = hi;
            res.ovf = 1'b1;
        end else if (s < lo) begin
            res.sum = lo;
            res.ovf = 1'b1;
        end else begin
            res.sum = s;
            res.ovf = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/pp_adder_tree_acc_if.sv
// Partial-product input bus and result bus of the adder tree accumulator.
interface pp_adder_tree_acc_if
    import sd4_mac_pkg::*;
#(
    parameter int NUM_PP = DEF_NUM_PP,
    parameter int PP_W   = DEF_PP_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int SUM_W  = PP_W + clog2(NUM_PP)
);
    logic [NUM_PP*PP_W-1:0] pp_in;
    logic                   in_valid;
    logic [LEN_W-1:0]       acc_len;
    logic                   flush;
    logic signed [SUM_W-1:0] tree_sum;
    logic                   tree_valid;
    logic signed [ACC_W-1:0] acc_out;
    logic                   ovf;
    logic                   out_valid;

    modport master (
        output pp_in, in_valid, acc_len, flush,
        input  tree_sum, tree_valid, acc_out, ovf, out_valid
    );

    modport slave (
        input  pp_in, in_valid, acc_len, flush,
        output tree_sum, tree_valid, acc_out, ovf, out_valid
    );
endinterface

// File: rtl/pp_adder_tree_acc_level.sv
// One registered reduction level: adds operand pairs (2j, 2j+1), passes an odd
// leftover through sign-extended, and only loads data when the input is valid.
module adder_tree_level #(
    parameter int IN_N = 2,
    parameter int IN_W = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid_i,
    input  logic [IN_N*IN_W-1:0]                  in_data_i,
    output logic                                  out_valid_o,
    output logic [((IN_N+1)/2)*(IN_W+1)-1:0]      out_data_o
);
    localparam int OUT_N = (IN_N + 1) / 2;
    localparam int OUT_W = IN_W + 1;

    logic [OUT_N*OUT_W-1:0] data_d;
    logic [OUT_N*OUT_W-1:0] data_q;
    logic                   valid_q;

    for (genvar j = 0; j < OUT_N; j++) begin : g_op
        logic signed [IN_W-1:0] op_a_s;
        assign op_a_s = in_data_i[2*j*IN_W +: IN_W];
        if (2 * j + 1 < IN_N) begin : g_add
            logic signed [IN_W-1:0] op_b_s;
            assign op_b_s = in_data_i[(2*j+1)*IN_W +: IN_W];
            assign data_d[j*OUT_W +: OUT_W] = OUT_W'(op_a_s) + OUT_W'(op_b_s);
        end else begin : g_pass
            assign data_d[j*OUT_W +: OUT_W] = OUT_W'(op_a_s);
        end
    end

    // Level register: valid always shifts, data holds across bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= data_d;
            end
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
endmodule

// File: rtl/pp_adder_tree_acc.sv
// Pipelined signed adder tree (one register per level) followed by a saturating
// group accumulator that emits one result per acc_len valid tree sums.
module pp_adder_tree_acc
    import sd4_mac_pkg::*;
#(
    parameter int NUM_PP = DEF_NUM_PP,
    parameter int PP_W   = DEF_PP_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input logic               clk,
    input logic               rst,
    pp_adder_tree_acc_if.slave bus
);
    localparam int LEVELS = clog2(NUM_PP);
    localparam int SUM_W  = PP_W + LEVELS;
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int IN_N = lvl_count(NUM_PP, k);
        localparam int IN_W = PP_W + k;
        logic                                 valid_s;
        logic [((IN_N+1)/2)*(IN_W+1)-1:0]     data_s;
        if (k == 0) begin : g_first
            adder_tree_level #(.IN_N(IN_N), .IN_W(IN_W)) u_level (
                .clk        (clk),
                .rst        (rst),
                .in_valid_i (bus.in_valid),
                .in_data_i  (bus.pp_in),
                .out_valid_o(valid_s),
                .out_data_o (data_s)
            );
        end else begin : g_next
            adder_tree_level #(.IN_N(IN_N), .IN_W(IN_W)) u_level (
                .clk        (clk),
                .rst        (rst),
                .in_valid_i (g_lvl[k-1].valid_s),
                .in_data_i  (g_lvl[k-1].data_s),
                .out_valid_o(valid_s),
                .out_data_o (data_s)
            );
        end
    end

    logic                     tree_valid_s;
    logic signed [SUM_W-1:0]  tree_sum_s;
    logic signed [ACC_W-1:0]  sum_ext_s;
    sat_res_t                 sat_s;
    logic [LEN_W-1:0]         cnt_new_s;

    logic [LEN_W-1:0]         cnt_q, cnt_d, len_q, len_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, acc_out_q, acc_out_d;
    logic                     ovf_q, ovf_d, ovf_out_q, ovf_out_d;
    logic                     out_valid_q, out_valid_d;

    assign tree_valid_s = g_lvl[LEVELS-1].valid_s;
    assign tree_sum_s   = g_lvl[LEVELS-1].data_s;
    assign sum_ext_s    = ACC_W'(tree_sum_s);

    // Accumulator next state: group start (count 0 or flush) reloads, otherwise saturating add.
    always_comb begin
        sat_s       = sat_add(64'(acc_q), 64'(sum_ext_s), ACC_W);
        cnt_new_s   = cnt_q + LEN_ONE;
        cnt_d       = cnt_q;
        len_d       = len_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        acc_out_d   = acc_out_q;
        ovf_out_d   = ovf_out_q;
        out_valid_d = 1'b0;
        if (tree_valid_s) begin
            if ((cnt_q == LEN_ZERO) || bus.flush) begin
                len_d     = (bus.acc_len == LEN_ZERO) ? LEN_ONE : bus.acc_len;
                acc_d     = sum_ext_s;
                ovf_d     = 1'b0;
                cnt_new_s = LEN_ONE;
            end else begin
                acc_d = ACC_W'(sat_s.sum);
                ovf_d = ovf_q | sat_s.ovf;
            end
            if (cnt_new_s == len_d) begin
                acc_out_d   = acc_d;
                ovf_out_d   = ovf_d;
                out_valid_d = 1'b1;
                cnt_d       = LEN_ZERO;
            end else begin
                cnt_d = cnt_new_s;
            end
        end else if (bus.flush) begin
            cnt_d = LEN_ZERO;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Accumulator and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= LEN_ZERO;
            len_q       <= LEN_ZERO;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            acc_out_q   <= '0;
            ovf_out_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            acc_out_q   <= acc_out_d;
            ovf_out_q   <= ovf_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.tree_valid = tree_valid_s;
    assign bus.tree_sum   = tree_sum_s;
    assign bus.acc_out    = acc_out_q;
    assign bus.ovf        = ovf_out_q;
    assign bus.out_valid  = out_valid_q;
endmodule

// File: tb/tb_pp_adder_tree_acc.sv
// Scoreboard bench: two instances (ACC_W 24 and 20) share stimulus; a reference
// model pushes expected tree sums and group results, a negedge monitor pops them.
module tb_pp_adder_tree_acc;
    localparam int NUM_PP  = 9;
    localparam int PP_W    = 16;
    localparam int LEN_W   = 8;
    localparam int LEVELS  = 4;
    localparam int ACC_W_A = 24;
    localparam int ACC_W_B = 20;

    typedef struct {
        longint val;
        bit     ovf;
        int     cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t   tq[2][$];
    exp_t   oq[2][$];
    int     m_cnt[2];
    int     m_len[2];
    longint m_acc[2];
    bit     m_ovf[2];
    int     accw[2] = '{ACC_W_A, ACC_W_B};
    bit     dl_v[LEVELS];
    longint dl_s[LEVELS];
    longint pp_v[NUM_PP];
    int     cur_len = 1;
    longint last_acc[2];
    bit     last_ovf[2];

    pp_adder_tree_acc_if #(.NUM_PP(NUM_PP), .PP_W(PP_W), .ACC_W(ACC_W_A), .LEN_W(LEN_W)) ifa ();
    pp_adder_tree_acc_if #(.NUM_PP(NUM_PP), .PP_W(PP_W), .ACC_W(ACC_W_B), .LEN_W(LEN_W)) ifb ();

    pp_adder_tree_acc #(.NUM_PP(NUM_PP), .PP_W(PP_W), .ACC_W(ACC_W_A), .LEN_W(LEN_W)) dut_a (
        .clk(clk), .rst(rst_n), .bus(ifa));
    pp_adder_tree_acc #(.NUM_PP(NUM_PP), .PP_W(PP_W), .ACC_W(ACC_W_B), .LEN_W(LEN_W)) dut_b (
        .clk(clk), .rst(rst_n), .bus(ifb));

    assign ifb.pp_in    = ifa.pp_in;
    assign ifb.in_valid = ifa.in_valid;
    assign ifb.acc_len  = ifa.acc_len;
    assign ifb.flush    = ifa.flush;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int d, input longint got, input longint exp,
                         input int gc, input int ec);
        n_cmp++;
        if (got !== exp || gc != ec) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0d at cycle %0d, expected %0d at cycle %0d",
                     name, d, got, gc, exp, ec);
        end
    endtask

    task automatic mon(input int d, input bit tv, input longint ts, input bit ov,
                       input longint ao, input bit o);
        exp_t e;
        if (tv) begin
            if (tq[d].size() == 0) begin
                check("tree_unexpected", d, ts, 0, cyc, -1);
            end else begin
                e = tq[d].pop_front();
                check("tree_sum", d, ts, e.val, cyc, e.cyc);
            end
        end
        if (ov) begin
            if (oq[d].size() == 0) begin
                check("out_unexpected", d, ao, 0, cyc, -1);
            end else begin
                e = oq[d].pop_front();
                check("acc_out", d, ao, e.val, cyc, e.cyc);
                check("ovf", d, longint'(o), longint'(e.ovf), cyc, e.cyc);
                last_acc[d] = e.val;
                last_ovf[d] = e.ovf;
            end
        end else begin
            check("acc_hold", d, ao, last_acc[d], 0, 0);
            check("ovf_hold", d, longint'(o), longint'(last_ovf[d]), 0, 0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            last_acc = '{0, 0};
            last_ovf = '{0, 0};
        end else begin
            mon(0, ifa.tree_valid, longint'(ifa.tree_sum), ifa.out_valid, longint'(ifa.acc_out), ifa.ovf);
            mon(1, ifb.tree_valid, longint'(ifb.tree_sum), ifb.out_valid, longint'(ifb.acc_out), ifb.ovf);
        end
    end

    // Group accumulator behaviour for one instance in the cycle a tree sum (or none) reaches it.
    task automatic acc_step(input int d, input bit tv, input longint s, input bit fl);
        longint t, hi, lo;
        exp_t   e;
        if (tv) begin
            if (m_cnt[d] == 0 || fl) begin
                m_len[d] = (cur_len == 0) ? 1 : cur_len;
                m_acc[d] = s;
                m_ovf[d] = 1'b0;
                m_cnt[d] = 1;
            end else begin
                hi = (longint'(1) <<< (accw[d] - 1)) - 1;
                lo = -hi - 1;
                t  = m_acc[d] + s;
                if (t > hi) begin t = hi; m_ovf[d] = 1'b1; end
                if (t < lo) begin t = lo; m_ovf[d] = 1'b1; end
                m_acc[d] = t;
                m_cnt[d]++;
            end
            if (m_cnt[d] == m_len[d]) begin
                e.val = m_acc[d]; e.ovf = m_ovf[d]; e.cyc = cyc + 1;
                oq[d].push_back(e);
                m_cnt[d] = 0;
            end
        end else if (fl) begin
            m_cnt[d] = 0;
        end
    endtask

    task automatic drive(input bit v, input bit fl);
        longint s;
        bit     av;
        longint as;
        exp_t   e;
        s = 0;
        for (int i = 0; i < NUM_PP; i++) begin
            s += pp_v[i];
            ifa.pp_in[i*PP_W +: PP_W] = pp_v[i][PP_W-1:0];
        end
        ifa.in_valid = v;
        ifa.flush    = fl;
        ifa.acc_len  = LEN_W'(cur_len);
        if (v) begin
            e.val = s; e.ovf = 1'b0; e.cyc = cyc + LEVELS;
            tq[0].push_back(e);
            tq[1].push_back(e);
        end
        av = dl_v[LEVELS-1];
        as = dl_s[LEVELS-1];
        for (int i = LEVELS - 1; i > 0; i--) begin
            dl_v[i] = dl_v[i-1];
            dl_s[i] = dl_s[i-1];
        end
        dl_v[0] = v;
        dl_s[0] = s;
        acc_step(0, av, as, fl);
        acc_step(1, av, as, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    task automatic set_all(input longint val);
        for (int i = 0; i < NUM_PP; i++) pp_v[i] = val;
    endtask

    task automatic set_sum(input longint sum);
        longint tot;
        tot = 0;
        for (int i = 0; i < NUM_PP - 1; i++) begin
            pp_v[i] = longint'($urandom_range(0, 2000)) - 1000;
            tot += pp_v[i];
        end
        pp_v[NUM_PP-1] = sum - tot;
    endtask

    task automatic set_random();
        logic signed [PP_W-1:0] r;
        int mode;
        mode = int'($urandom_range(0, 4));
        for (int i = 0; i < NUM_PP; i++) begin
            r = PP_W'($urandom);
            pp_v[i] = (mode == 0) ? 32767 : (mode == 1) ? -32768 : longint'(r);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_tree_sum", 0, longint'(ifa.tree_sum), 0, 0, 0);
        check("rst_valids", 0, longint'({ifa.tree_valid, ifa.out_valid, ifb.tree_valid, ifb.out_valid}), 0, 0, 0);
        check("rst_acc_out", 0, longint'(ifa.acc_out), 0, 0, 0);
        check("rst_acc_out", 1, longint'(ifb.acc_out), 0, 0, 0);
        check("rst_ovf", 0, longint'({ifa.ovf, ifb.ovf}), 0, 0, 0);
        for (int d = 0; d < 2; d++) begin
            tq[d].delete();
            oq[d].delete();
            m_cnt[d] = 0; m_len[d] = 0; m_acc[d] = 0; m_ovf[d] = 1'b0;
        end
        for (int i = 0; i < LEVELS; i++) begin
            dl_v[i] = 1'b0;
            dl_s[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        ifa.pp_in    = '0;
        ifa.in_valid = 1'b0;
        ifa.acc_len  = '0;
        ifa.flush    = 1'b0;
        set_all(0);
        do_reset();

        // Pass-through: 8 x 100 and -300 -> 500
        cur_len = 1;
        for (int i = 0; i < NUM_PP - 1; i++) pp_v[i] = 100;
        pp_v[NUM_PP-1] = -300;
        drive(1'b1, 1'b0);
        idle(6);

        // Extremes
        set_all(-32768); drive(1'b1, 1'b0);
        set_all(32767);  drive(1'b1, 1'b0);
        idle(6);

        // Grouping with a gap
        cur_len = 4;
        idle(LEVELS + 1);
        set_sum(1000); drive(1'b1, 1'b0);
        set_sum(1000); drive(1'b1, 1'b0);
        idle(2);
        set_sum(1000); drive(1'b1, 1'b0);
        set_sum(1000); drive(1'b1, 1'b0);
        idle(6);

        // Saturation on the 20-bit instance, then a clean group
        cur_len = 2;
        idle(LEVELS + 1);
        set_all(32767); drive(1'b1, 1'b0); drive(1'b1, 1'b0);
        set_sum(10);    drive(1'b1, 1'b0); drive(1'b1, 1'b0);
        idle(6);

        // Flush alone discards the partial group
        cur_len = 3;
        idle(LEVELS + 1);
        set_sum(7); drive(1'b1, 1'b0); drive(1'b1, 1'b0);
        idle(4);
        drive(1'b0, 1'b1);
        set_sum(10); drive(1'b1, 1'b0); drive(1'b1, 1'b0); drive(1'b1, 1'b0);
        idle(6);

        // Flush coincident with a tree sum of 5
        cur_len = 1;
        idle(LEVELS + 1);
        set_sum(5); drive(1'b1, 1'b0);
        idle(3);
        drive(1'b0, 1'b1);
        idle(6);

        // Reset mid-stream, then a fresh group
        cur_len = 3;
        idle(LEVELS + 1);
        set_sum(50); drive(1'b1, 1'b0); drive(1'b1, 1'b0); drive(1'b1, 1'b0);
        do_reset();
        set_sum(20); drive(1'b1, 1'b0); drive(1'b1, 1'b0); drive(1'b1, 1'b0);
        idle(6);

        // Randomised segments
        for (int seg = 0; seg < 25; seg++) begin
            cur_len = int'($urandom_range(0, 6));
            idle(LEVELS + 1);
            repeat (30) begin
                set_random();
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
            end
        end
        idle(LEVELS + 3);

        for (int d = 0; d < 2; d++) begin
            check("tree_pending", d, longint'(tq[d].size()), 0, 0, 0);
            check("out_pending", d, longint'(oq[d].size()), 0, 0, 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
